id_ex: RTL and testbench

- Pipeline register between the decode stage (instruction plus register-file read) and the `ex` stage.
- Captures the instruction, its PC and both source operands each cycle.
- Bypasses the result that `ex` is writing in the same cycle, so back-to-back dependent instructions see fresh operands.
- Supports hold (stall) and flush (branch/jump kill, bubble = NOP), and keeps stall/flush event counters for debug.

---
 rtl/id_ex.sv | 135 +++++++++++++
 tb/tb_id_ex.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex.sv
// Decode-to-execute pipeline register with EX-result bypass, stall/flush control
// and saturating stall/flush event counters for debug visibility.
module id_ex #(
    parameter logic [31:0] NOP_INS    = 32'h0000_0013,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ins_i,
    input  logic [31:0]      ins_addr_i,
    input  logic             ins_valid_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [31:0]      ex_rd_data_i,
    input  logic             ex_rd_wr_en_i,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic [31:0]      ins_o,
    output logic [31:0]      ins_addr_o,
    output logic [31:0]      rs1_data_o,
    output logic [31:0]      rs2_data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [31:0]      r_ins;
    logic [31:0]      r_ins_addr;
    logic [31:0]      r_rs1_data;
    logic [31:0]      r_rs2_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [31:0]      w_ins_d;
    logic [31:0]      w_ins_addr_d;
    logic [31:0]      w_rs1_data_d;
    logic [31:0]      w_rs2_data_d;
    logic             w_valid_d;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] w_flush_cnt_d;

    logic             w_ex_wr;
    logic             w_ld_rs1_hit;
    logic             w_ld_rs2_hit;
    logic             w_hd_rs1_hit;
    logic             w_hd_rs2_hit;
    logic             w_stall;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    assign w_ex_wr      = ex_rd_wr_en_i && (ex_rd_addr_i != 5'd0);
    assign w_ld_rs1_hit = w_ex_wr && (ex_rd_addr_i == rs1_addr_i);
    assign w_ld_rs2_hit = w_ex_wr && (ex_rd_addr_i == rs2_addr_i);
    // While stalled, match against the source fields of the instruction already held.
    assign w_hd_rs1_hit = w_ex_wr && (ex_rd_addr_i == r_ins[19:15]);
    assign w_hd_rs2_hit = w_ex_wr && (ex_rd_addr_i == r_ins[24:20]);
    assign w_stall      = hold_i && !flush_i;

    always_comb begin
        w_ins_d      = r_ins;
        w_ins_addr_d = r_ins_addr;
        w_rs1_data_d = r_rs1_data;
        w_rs2_data_d = r_rs2_data;
        w_valid_d    = r_valid;
        if (flush_i) begin
            w_ins_d      = NOP_INS;
            w_ins_addr_d = RESET_ADDR;
            w_rs1_data_d = 32'd0;
            w_rs2_data_d = 32'd0;
            w_valid_d    = 1'b0;
        end else if (hold_i) begin
            if (w_hd_rs1_hit) begin
                w_rs1_data_d = ex_rd_data_i;
            end
            if (w_hd_rs2_hit) begin
                w_rs2_data_d = ex_rd_data_i;
            end
        end else begin
            w_ins_d      = ins_valid_i ? ins_i : NOP_INS;
            w_ins_addr_d = ins_addr_i;
            w_valid_d    = ins_valid_i;
            if (ins_valid_i) begin
                w_rs1_data_d = w_ld_rs1_hit ? ex_rd_data_i : rs1_data_i;
                w_rs2_data_d = w_ld_rs2_hit ? ex_rd_data_i : rs2_data_i;
            end else begin
                w_rs1_data_d = 32'd0;
                w_rs2_data_d = 32'd0;
            end
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt;
        w_flush_cnt_d = r_flush_cnt;
        if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
        end
        if (flush_i && (r_flush_cnt != {CNT_W{1'b1}})) begin
            w_flush_cnt_d = r_flush_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ins       <= NOP_INS;
            r_ins_addr  <= RESET_ADDR;
            r_rs1_data  <= 32'd0;
            r_rs2_data  <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_ins       <= w_ins_d;
            r_ins_addr  <= w_ins_addr_d;
            r_rs1_data  <= w_rs1_data_d;
            r_rs2_data  <= w_rs2_data_d;
            r_valid     <= w_valid_d;
            r_stall_cnt <= w_stall_cnt_d;
            r_flush_cnt <= w_flush_cnt_d;
        end
    end

    assign ins_o       = r_ins;
    assign ins_addr_o  = r_ins_addr;
    assign rs1_data_o  = r_rs1_data;
    assign rs2_data_o  = r_rs2_data;
    assign valid_o     = r_valid;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed vector table, stall/flush/saturation
// sequences, then randomized traffic against an event-level reference model.
module tb_id_ex;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0020_81B3;  // add x3,x1,x2

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins_i, ins_addr_i, rs1_data_i, rs2_data_i, ex_rd_data_i;
    logic        ins_valid_i, ex_rd_wr_en_i, hold_i, flush_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, ex_rd_addr_i;

    logic [31:0] ins_o, ins_addr_o, rs1_data_o, rs2_data_o;
    logic        valid_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic [31:0] s_ins_o, s_ins_addr_o, s_rs1_data_o, s_rs2_data_o;
    logic        s_valid_o;
    logic [3:0]  s_stall_cnt_o, s_flush_cnt_o;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: architectural view plus raw event counts since reset.
    logic [31:0] m_ins, m_addr, m_rs1, m_rs2;
    logic        m_valid;
    int          m_stalls, m_flushes;

    always #5 clk = ~clk;

    id_ex u_dut (
        .clk(clk), .rst(rst), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .ins_valid_i(ins_valid_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_rd_data_i(ex_rd_data_i), .ex_rd_wr_en_i(ex_rd_wr_en_i), .hold_i(hold_i),
        .flush_i(flush_i), .ins_o(ins_o), .ins_addr_o(ins_addr_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .valid_o(valid_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    id_ex #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst(rst), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .ins_valid_i(ins_valid_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_rd_data_i(ex_rd_data_i), .ex_rd_wr_en_i(ex_rd_wr_en_i), .hold_i(hold_i),
        .flush_i(flush_i), .ins_o(s_ins_o), .ins_addr_o(s_ins_addr_o),
        .rs1_data_o(s_rs1_data_o), .rs2_data_o(s_rs2_data_o), .valid_o(s_valid_o),
        .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] addr;
        logic        vld;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        we;
        logic [31:0] e_ins;
        logic [31:0] e_addr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_vld;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Forwarded value for a source register, or the fallback when EX is not writing it.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] fallback);
        if (ex_rd_wr_en_i && ex_rd_addr_i != 0 && ex_rd_addr_i == src) return ex_rd_data_i;
        return fallback;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_ins = NOP; m_addr = 0; m_rs1 = 0; m_rs2 = 0; m_valid = 0;
            m_stalls = 0; m_flushes = 0;
        end else if (flush_i) begin
            m_ins = NOP; m_addr = 0; m_rs1 = 0; m_rs2 = 0; m_valid = 0;
            m_flushes++;
        end else if (hold_i) begin
            m_rs1 = fwd(m_ins[19:15], m_rs1);
            m_rs2 = fwd(m_ins[24:20], m_rs2);
            m_stalls++;
        end else begin
            m_valid = ins_valid_i;
            m_addr  = ins_addr_i;
            m_ins   = ins_valid_i ? ins_i : NOP;
            m_rs1   = ins_valid_i ? fwd(rs1_addr_i, rs1_data_i) : 32'd0;
            m_rs2   = ins_valid_i ? fwd(rs2_addr_i, rs2_data_i) : 32'd0;
        end
    endtask

    task automatic check_model();
        chk("m_ins", ins_o, m_ins);
        chk("m_addr", ins_addr_o, m_addr);
        chk("m_rs1", rs1_data_o, m_rs1);
        chk("m_rs2", rs2_data_o, m_rs2);
        chk("m_valid", {31'd0, valid_o}, {31'd0, m_valid});
        chk("m_stall16", {16'd0, stall_cnt_o}, sat(m_stalls, 65535));
        chk("m_flush16", {16'd0, flush_cnt_o}, sat(m_flushes, 65535));
        chk("m_s_ins", s_ins_o, m_ins);
        chk("m_s_rs1", s_rs1_data_o, m_rs1);
        chk("m_s_rs2", s_rs2_data_o, m_rs2);
        chk("m_s_addr", s_ins_addr_o, m_addr);
        chk("m_s_valid", {31'd0, s_valid_o}, {31'd0, m_valid});
        chk("m_stall4", {28'd0, s_stall_cnt_o}, sat(m_stalls, 15));
        chk("m_flush4", {28'd0, s_flush_cnt_o}, sat(m_flushes, 15));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        rst = 0; hold_i = 0; flush_i = 0; ex_rd_wr_en_i = 0;
        ex_rd_addr_i = 0; ex_rd_data_i = 0;
    endtask

    task automatic load_add(input logic [31:0] pc);
        ins_i = ADD; ins_addr_i = pc; ins_valid_i = 1;
        rs1_addr_i = 5'd1; rs2_addr_i = 5'd2; rs1_data_i = 5; rs2_data_i = 7;
    endtask

    initial begin
        vecs[0] = '{ADD, 32'h10, 1, 1, 2, 5, 7, 0, 0, 0, ADD, 32'h10, 5, 7, 1};
        vecs[1] = '{ADD, 32'h14, 1, 1, 2, 5, 7, 1, 32'hDEAD_BEEF, 1,
                    ADD, 32'h14, 32'hDEAD_BEEF, 7, 1};
        vecs[2] = '{ADD, 32'h18, 1, 1, 2, 5, 7, 0, 32'hDEAD_BEEF, 1, ADD, 32'h18, 5, 7, 1};
        vecs[3] = '{ADD, 32'h1C, 1, 1, 2, 5, 7, 2, 32'h1234, 0, ADD, 32'h1C, 5, 7, 1};
        vecs[4] = '{32'h33, 32'h20, 1, 0, 0, 0, 0, 0, 32'hAAAA, 1, 32'h33, 32'h20, 0, 0, 1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h24, 0, 1, 2, 9, 9, 1, 77, 1, NOP, 32'h24, 0, 0, 0};
        vecs[6] = '{ADD, 32'h28, 1, 1, 2, 5, 7, 2, 32'h99, 1, ADD, 32'h28, 5, 32'h99, 1};

        // Reset with random inputs present.
        idle_inputs();
        rst = 1; hold_i = 1; flush_i = 1;
        ins_i = $urandom; ins_addr_i = $urandom; ins_valid_i = 1;
        rs1_addr_i = 5'd1; rs2_addr_i = 5'd2; rs1_data_i = $urandom; rs2_data_i = $urandom;
        tick();
        tick();
        chk("rst_ins", ins_o, 32'h0000_0013);
        chk("rst_addr", ins_addr_o, 32'h0);
        chk("rst_rs1", rs1_data_o, 32'h0);
        chk("rst_rs2", rs2_data_o, 32'h0);
        chk("rst_valid", {31'd0, valid_o}, 32'h0);
        chk("rst_stall", {16'd0, stall_cnt_o}, 32'h0);
        chk("rst_flush", {16'd0, flush_cnt_o}, 32'h0);

        // Directed load / bypass vectors.
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            ins_i = vecs[i].ins; ins_addr_i = vecs[i].addr; ins_valid_i = vecs[i].vld;
            rs1_addr_i = vecs[i].a1; rs2_addr_i = vecs[i].a2;
            rs1_data_i = vecs[i].d1; rs2_data_i = vecs[i].d2;
            ex_rd_addr_i = vecs[i].ea; ex_rd_data_i = vecs[i].ed; ex_rd_wr_en_i = vecs[i].we;
            tick();
            chk($sformatf("vec%0d_ins", i), ins_o, vecs[i].e_ins);
            chk($sformatf("vec%0d_addr", i), ins_addr_o, vecs[i].e_addr);
            chk($sformatf("vec%0d_rs1", i), rs1_data_o, vecs[i].e_rs1);
            chk($sformatf("vec%0d_rs2", i), rs2_data_o, vecs[i].e_rs2);
            chk($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].e_vld});
        end

        // Hold for three cycles; EX writes x2 during the second one.
        idle_inputs();
        load_add(32'h40);
        tick();
        hold_i = 1;
        ins_i = 32'hFFFF_FFFF; ins_addr_i = 32'h80; rs2_data_i = 32'h1111;
        tick();
        chk("hold1_rs2", rs2_data_o, 32'h7);
        ex_rd_wr_en_i = 1; ex_rd_addr_i = 5'd2; ex_rd_data_i = 32'h55;
        tick();
        ex_rd_wr_en_i = 0;
        tick();
        chk("hold_ins", ins_o, ADD);
        chk("hold_addr", ins_addr_o, 32'h40);
        chk("hold_rs1", rs1_data_o, 32'h5);
        chk("hold_rs2", rs2_data_o, 32'h55);
        chk("hold_stall", {16'd0, stall_cnt_o}, 32'd3);

        // Flush together with hold: bubble wins, no stall counted.
        flush_i = 1;
        tick();
        chk("flush_ins", ins_o, NOP);
        chk("flush_valid", {31'd0, valid_o}, 32'h0);
        chk("flush_addr", ins_addr_o, 32'h0);
        chk("flush_cnt", {16'd0, flush_cnt_o}, 32'd1);
        chk("flush_stall", {16'd0, stall_cnt_o}, 32'd3);

        // Saturation of a 4-bit counter.
        idle_inputs();
        rst = 1;
        tick();
        rst = 0; hold_i = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall4", {28'd0, s_stall_cnt_o}, 32'd15);
        chk("sat_stall16", {16'd0, stall_cnt_o}, 32'd20);
        hold_i = 0; rst = 1;
        tick();
        chk("sat_rst4", {28'd0, s_stall_cnt_o}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            hold_i = ($urandom_range(0, 99) < 30);
            flush_i = ($urandom_range(0, 99) < 10);
            ins_valid_i = ($urandom_range(0, 99) < 80);
            ins_i = $urandom; ins_addr_i = $urandom;
            rs1_addr_i = 5'($urandom_range(0, 7)); rs2_addr_i = 5'($urandom_range(0, 7));
            rs1_data_i = $urandom; rs2_data_i = $urandom;
            ex_rd_wr_en_i = ($urandom_range(0, 99) < 60);
            ex_rd_addr_i = 5'($urandom_range(0, 7));
            ex_rd_data_i = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
